dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory (combinational read, write on clock edge with bit mask). It sits between the memory and its two users: requester 0 (core load/store unit) and requester 1 (DMA/debug port). Each cycle it grants at most one request and forwards that request's fields to the memory. It returns a registered response one cycle later and supports locked sequences so a requester can perform an atomic read-modify-write.

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter/sequencer for the single-port data memory
// Optional feature macro: DMEM_ARB_RR_EN (round-robin on contention; default is fixed priority to requester 0).
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,

  input  logic          i_r0_valid,
  output logic          o_r0_ready,
  input  logic [AW-1:0] i_r0_addr,
  input  logic [DW-1:0] i_r0_write_data,
  input  logic [DW-1:0] i_r0_write_mask,
  input  logic          i_r0_write_enable,
  input  logic          i_r0_lock,
  output logic          o_r0_rvalid,
  output logic [DW-1:0] o_r0_rdata,

  input  logic          i_r1_valid,
  output logic          o_r1_ready,
  input  logic [AW-1:0] i_r1_addr,
  input  logic [DW-1:0] i_r1_write_data,
  input  logic [DW-1:0] i_r1_write_mask,
  input  logic          i_r1_write_enable,
  input  logic          i_r1_lock,
  output logic          o_r1_rvalid,
  output logic [DW-1:0] o_r1_rdata,

  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_write_data,
  output logic [DW-1:0] o_mem_write_mask,
  output logic          o_mem_write_enable,
  input  logic [DW-1:0] i_mem_read_data
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   grant0;
  logic   grant1;
  logic   accept0;
  logic   accept1;

  // A lock owner excludes the other requester even while the owner is idle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      ARB: begin
        if (i_r0_valid && i_r1_valid) begin
`ifdef DMEM_ARB_RR_EN
          grant0 = last_grant;
          grant1 = ~last_grant;
`else
          grant0 = 1'b1;
`endif
        end else begin
          grant0 = i_r0_valid;
          grant1 = i_r1_valid;
        end
      end
      LOCK0:   grant0 = i_r0_valid;
      LOCK1:   grant1 = i_r1_valid;
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  assign accept0    = i_r0_valid & grant0;
  assign accept1    = i_r1_valid & grant1;
  assign o_r0_ready = grant0;
  assign o_r1_ready = grant1;

  // Requester 0 owns the memory bus whenever requester 1 is not granted.
  always_comb begin
    o_mem_addr         = i_r0_addr;
    o_mem_write_data   = i_r0_write_data;
    o_mem_write_mask   = i_r0_write_mask;
    o_mem_write_enable = grant0 & i_r0_write_enable;
    if (grant1) begin
      o_mem_addr         = i_r1_addr;
      o_mem_write_data   = i_r1_write_data;
      o_mem_write_mask   = i_r1_write_mask;
      o_mem_write_enable = i_r1_write_enable;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ARB;
      last_grant  <= 1'b1;
      o_r0_rvalid <= 1'b0;
      o_r1_rvalid <= 1'b0;
      o_r0_rdata  <= '0;
      o_r1_rdata  <= '0;
    end else begin
      o_r0_rvalid <= accept0;
      o_r1_rvalid <= accept1;
      // Read data is captured at the grant edge, so writes return the pre-write word.
      if (accept0) o_r0_rdata <= i_mem_read_data;
      if (accept1) o_r1_rdata <= i_mem_read_data;
      last_grant <= accept1 ? 1'b1 : (accept0 ? 1'b0 : last_grant);
      case (state)
        ARB: begin
          if (accept0 && i_r0_lock)      state <= LOCK0;
          else if (accept1 && i_r1_lock) state <= LOCK1;
        end
        LOCK0:   if (accept0 && !i_r0_lock) state <= ARB;
        LOCK1:   if (accept1 && !i_r1_lock) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter with a 16-word memory model
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid, r0_ready, r0_we, r0_lock, r0_rvalid;
  logic [31:0] r0_addr, r0_wd, r0_wm, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_lock, r1_rvalid;
  logic [31:0] r1_addr, r1_wd, r1_wm, r1_rdata;
  logic [31:0] mem_addr, mem_wd, mem_wm, mem_rd;
  logic        mem_we;
  logic        preload = 1'b1;
  logic [31:0] mem [0:15];
  logic [31:0] snap [0:15];

  int n_applied = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_r0_valid(r0_valid), .o_r0_ready(r0_ready), .i_r0_addr(r0_addr),
    .i_r0_write_data(r0_wd), .i_r0_write_mask(r0_wm), .i_r0_write_enable(r0_we),
    .i_r0_lock(r0_lock), .o_r0_rvalid(r0_rvalid), .o_r0_rdata(r0_rdata),
    .i_r1_valid(r1_valid), .o_r1_ready(r1_ready), .i_r1_addr(r1_addr),
    .i_r1_write_data(r1_wd), .i_r1_write_mask(r1_wm), .i_r1_write_enable(r1_we),
    .i_r1_lock(r1_lock), .o_r1_rvalid(r1_rvalid), .o_r1_rdata(r1_rdata),
    .o_mem_addr(mem_addr), .o_mem_write_data(mem_wd), .o_mem_write_mask(mem_wm),
    .o_mem_write_enable(mem_we), .i_mem_read_data(mem_rd)
  );

  assign mem_rd = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(i) * 32'h1111_1111;
      mem[5] <= 32'hDEAD_BEEF;
      mem[7] <= 32'hAAAA_AAAA;
    end else if (mem_we) begin
      mem[mem_addr[3:0]] <= (mem[mem_addr[3:0]] & ~mem_wm) | (mem_wd & mem_wm);
    end
  end

  typedef struct {
    logic        v0, we0, lk0;
    logic [31:0] a0, wd0, wm0;
    logic        v1, we1, lk1;
    logic [31:0] a1, wd1, wm1;
    logic        e_rdy0, e_rdy1, e_we, e_rv0, e_rv1;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(
    input logic v0, input logic we0, input logic lk0, input logic [31:0] a0, input logic [31:0] wd0, input logic [31:0] wm0,
    input logic v1, input logic we1, input logic lk1, input logic [31:0] a1, input logic [31:0] wd1, input logic [31:0] wm1,
    input logic rdy0, input logic rdy1, input logic mwe, input logic rv0, input logic rv1,
    input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.wd0 = wd0; v.wm0 = wm0;
    v.v1 = v1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.wd1 = wd1; v.wm1 = wm1;
    v.e_rdy0 = rdy0; v.e_rdy1 = rdy1; v.e_we = mwe; v.e_rv0 = rv0; v.e_rv1 = rv1;
    v.e_rd0 = rd0; v.e_rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic lk0, input logic [31:0] a0, input logic [31:0] wd0, input logic [31:0] wm0,
                       input logic v1, input logic we1, input logic lk1, input logic [31:0] a1, input logic [31:0] wd1, input logic [31:0] wm1);
    r0_valid = v0; r0_we = we0; r0_lock = lk0; r0_addr = a0; r0_wd = wd0; r0_wm = wm0;
    r1_valid = v1; r1_we = we1; r1_lock = lk1; r1_addr = a1; r1_wd = wd1; r1_wm = wm1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] h1;
    logic        c;
    h1 = RR ? 32'h2222_2222 : 32'h6666_6666;
    //            v0 we lk a0 wd0 wm0                  v1 we lk a1 wd1 wm1                         rdy0 rdy1 we rv0 rv1 rd0 rd1
    vecs[0]  = mk(1, 0, 0, 5, 0, 0,                    0, 0, 0, 0, 0, 0,                           1, 0, 0, 0, 0, 32'h0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,                    1, 1, 0, 7, 32'h1234_5678, 32'h0000_FFFF,   0, 1, 1, 1, 0, 32'hDEAD_BEEF, 32'h0);
    vecs[2]  = mk(1, 0, 0, 7, 0, 0,                    0, 0, 0, 0, 0, 0,                           1, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'hAAAA_AAAA);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,                    1, 0, 0, 6, 0, 0,                           0, 1, 0, 1, 0, 32'hAAAA_5678, 32'hAAAA_AAAA);
    vecs[4]  = mk(1, 0, 0, 1, 0, 0,                    1, 0, 0, 2, 0, 0,                           1, 0, 0, 0, 1, 32'hAAAA_5678, 32'h6666_6666);
    vecs[5]  = mk(1, 0, 0, 1, 0, 0,                    1, 0, 0, 2, 0, 0,                           !RR, RR, 0, 1, 0, 32'h1111_1111, 32'h6666_6666);
    vecs[6]  = mk(1, 0, 0, 1, 0, 0,                    1, 0, 0, 2, 0, 0,                           1, 0, 0, !RR, RR, 32'h1111_1111, h1);
    vecs[7]  = mk(1, 0, 0, 1, 0, 0,                    1, 0, 0, 2, 0, 0,                           !RR, RR, 0, 1, 0, 32'h1111_1111, h1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0,                           0, 0, 0, !RR, RR, 32'h1111_1111, h1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,                    1, 0, 1, 3, 0, 0,                           0, 1, 0, 0, 0, 32'h1111_1111, h1);
    vecs[10] = mk(1, 0, 0, 4, 0, 0,                    0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 1, 32'h1111_1111, 32'h3333_3333);
    vecs[11] = mk(1, 0, 0, 4, 0, 0,                    0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 32'h1111_1111, 32'h3333_3333);
    vecs[12] = mk(1, 0, 0, 4, 0, 0,                    1, 1, 0, 3, 32'hCAFE_F00D, 32'hFFFF_FFFF,   0, 1, 1, 0, 0, 32'h1111_1111, 32'h3333_3333);
    vecs[13] = mk(1, 0, 0, 4, 0, 0,                    0, 0, 0, 0, 0, 0,                           1, 0, 0, 0, 1, 32'h1111_1111, 32'h3333_3333);
    vecs[14] = mk(1, 0, 0, 3, 0, 0,                    0, 0, 0, 0, 0, 0,                           1, 0, 0, 1, 0, 32'h4444_4444, 32'h3333_3333);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0,                           0, 0, 0, 1, 0, 32'hCAFE_F00D, 32'h3333_3333);

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("reset_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("reset_r0_rdata", r0_rdata, 32'd0);
    chk("reset_r1_rdata", r1_rdata, 32'd0);
    preload = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v0, vecs[i].we0, vecs[i].lk0, vecs[i].a0, vecs[i].wd0, vecs[i].wm0,
            vecs[i].v1, vecs[i].we1, vecs[i].lk1, vecs[i].a1, vecs[i].wd1, vecs[i].wm1);
      #3;
      chk($sformatf("v%0d_r0_ready", i), 32'(r0_ready), 32'(vecs[i].e_rdy0));
      chk($sformatf("v%0d_r1_ready", i), 32'(r1_ready), 32'(vecs[i].e_rdy1));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_rdy1 ? vecs[i].a1 : vecs[i].a0);
      chk($sformatf("v%0d_r0_rvalid", i), 32'(r0_rvalid), 32'(vecs[i].e_rv0));
      chk($sformatf("v%0d_r1_rvalid", i), 32'(r1_rvalid), 32'(vecs[i].e_rv1));
      chk($sformatf("v%0d_r0_rdata", i), r0_rdata, vecs[i].e_rd0);
      chk($sformatf("v%0d_r1_rdata", i), r1_rdata, vecs[i].e_rd1);
      @(posedge clk);
      #1;
    end

    // Reset while requester 1 holds a lock and has a response pending.
    drive(0, 0, 0, 32'd0, 32'd0, 32'd0, 1, 0, 1, 32'd3, 32'd0, 32'd0);
    #3;
    chk("lock_r1_ready", 32'(r1_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 32'd4, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("lock_r0_blocked", 32'(r0_ready), 32'd0);
    chk("lock_r1_rvalid", 32'(r1_rvalid), 32'd1);
    chk("lock_r1_rdata", r1_rdata, 32'hCAFE_F00D);
    rst = 1'b1;
    #1;
    chk("rst_clears_rvalid", 32'(r1_rvalid), 32'd0);
    chk("rst_clears_rdata", r1_rdata, 32'd0);
    chk("rst_state_arb", 32'(r0_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_r0_grant", 32'(r0_ready), 32'd1);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("post_rst_r0_rvalid", 32'(r0_rvalid), 32'd1);
    chk("post_rst_r0_rdata", r0_rdata, 32'h4444_4444);

    // Back-to-back on requester 0: masked write, full write, read-after-write.
    drive(1, 1, 0, 32'd8, 32'h0F0F_0F0F, 32'hFF00_FF00, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("b2b_w8_ready", 32'(r0_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(1, 1, 0, 32'd9, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("b2b_w9_ready", 32'(r0_ready), 32'd1);
    chk("b2b_w8_ack", r0_rdata, 32'h8888_8888);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 32'd8, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("b2b_w9_ack", r0_rdata, 32'h9999_9999);
    chk("b2b_rvalid", 32'(r0_rvalid), 32'd1);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("b2b_r8_data", r0_rdata, 32'h0F88_0F88);

    // Ten idle cycles leave memory untouched.
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #4;
      chk($sformatf("idle%0d_mem_we", k), 32'(mem_we), 32'd0);
    end
    c = 1'b1;
    for (int i = 0; i < 16; i++) if (mem[i] !== snap[i]) c = 1'b0;
    chk("idle_mem_unchanged", 32'(c), 32'd1);
    chk("idle_mem9", mem[9], 32'h5A5A_5A5A);
    chk("idle_mem3", mem[3], 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
